// File: rtl/cpu_run_controller.sv
// cpu_run_controller: turns the board push-buttons into the core's active-low
// reset and HALT, with free-run, halted, single-step and slow-run modes, and
// counts the cycles in which the core was allowed to advance.
module cpu_run_controller #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SLOW_PERIOD     = 50_000_000,
  parameter int CNT_W           = 26
) (
  input  logic        CLK100MHZ,
  input  logic        sw0,
  input  logic        btn_run,
  input  logic        btn_halt,
  input  logic        btn_step,
  input  logic        btn_slow,
  output logic        cpu_rst_n,
  output logic        cpu_halt,
  output logic [1:0]  run_state,
  output logic [15:0] step_count
);

  localparam int NB     = 4;
  localparam int B_RUN  = 0;
  localparam int B_HALT = 1;
  localparam int B_STEP = 2;
  localparam int B_SLOW = 3;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(SLOW_PERIOD - 1);

  typedef enum logic [1:0] {
    S_HALTED  = 2'd0,
    S_RUNNING = 2'd1,
    S_STEP    = 2'd2,
    S_SLOW    = 2'd3
  } state_t;

  logic [NB-1:0]    btn_raw;
  logic [NB-1:0]    sync_p0;
  logic [NB-1:0]    sync_p1;
  logic [NB-1:0]    db;
  logic [NB-1:0]    db_d;
  logic [NB-1:0]    press;
  logic [CNT_W-1:0] db_cnt [NB];

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] slow_tmr;

  assign btn_raw = {btn_slow, btn_step, btn_halt, btn_run};

  // Stage p0/p1: two-flop synchronizer, then a per-button stability counter
  // that only flips the debounced level after DEBOUNCE_CYCLES mismatches in a row.
  always_ff @(posedge CLK100MHZ) begin
    if (sw0) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      db      <= '0;
      db_d    <= '0;
      for (int i = 0; i < NB; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
      db_d    <= db;
      for (int i = 0; i < NB; i++) begin
        if (sync_p1[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= ~db[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // One-cycle pulse on each accepted press; releases never pulse.
  assign press = db & ~db_d;

  // Run-mode state register.
  always_ff @(posedge CLK100MHZ) begin
    if (sw0) begin
      state <= S_HALTED;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode with halt > step > run > slow priority, plus Moore halt output.
  always_comb begin
    state_nx = state;
    cpu_halt = 1'b1;
    unique case (state)
      S_HALTED: begin
        if (press[B_HALT]) begin
          state_nx = S_HALTED;
        end else if (press[B_STEP]) begin
          state_nx = S_STEP;
        end else if (press[B_RUN]) begin
          state_nx = S_RUNNING;
        end else if (press[B_SLOW]) begin
          state_nx = S_SLOW;
        end
      end
      S_RUNNING: begin
        cpu_halt = 1'b0;
        if (press[B_HALT] || press[B_STEP] || press[B_SLOW]) begin
          state_nx = S_HALTED;
        end
      end
      S_STEP: begin
        // Exactly one enabled cycle; presses landing here are dropped.
        cpu_halt = 1'b0;
        state_nx = S_HALTED;
      end
      S_SLOW: begin
        cpu_halt = (slow_tmr != SLOW_LAST);
        if (press[B_HALT]) begin
          state_nx = S_HALTED;
        end else if (press[B_RUN]) begin
          state_nx = S_RUNNING;
        end
      end
      default: begin
        state_nx = S_HALTED;
      end
    endcase
  end

  // Slow-run phase timer: zero on entry, then free-runs modulo SLOW_PERIOD.
  always_ff @(posedge CLK100MHZ) begin
    if (sw0) begin
      slow_tmr <= '0;
    end else if (state == S_SLOW && state_nx == S_SLOW) begin
      slow_tmr <= (slow_tmr == SLOW_LAST) ? '0 : slow_tmr + CNT_W'(1);
    end else begin
      slow_tmr <= '0;
    end
  end

  // Core reset follows the switch one clock later.
  always_ff @(posedge CLK100MHZ) begin
    cpu_rst_n <= ~sw0;
  end

  // Count every cycle the core actually advanced; wraps at 16 bits.
  always_ff @(posedge CLK100MHZ) begin
    if (sw0) begin
      step_count <= '0;
    end else if (!cpu_halt && cpu_rst_n) begin
      step_count <= step_count + 16'd1;
    end
  end

  assign run_state = state;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Bench for cpu_run_controller: cycle table, directed multi-cycle sequences,
// random button traffic checked against a behavioural model every cycle.
module tb_cpu_run_controller;

  localparam int DB = 4;
  localparam int SP = 8;

  logic        clk = 1'b0;
  logic        sw0 = 1'b1;
  logic        btn_run = 1'b0;
  logic        btn_halt = 1'b0;
  logic        btn_step = 1'b0;
  logic        btn_slow = 1'b0;
  logic        cpu_rst_n;
  logic        cpu_halt;
  logic [1:0]  run_state;
  logic [15:0] step_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cpu_run_controller #(
    .DEBOUNCE_CYCLES(DB),
    .SLOW_PERIOD    (SP),
    .CNT_W          (26)
  ) dut (
    .CLK100MHZ (clk),
    .sw0       (sw0),
    .btn_run   (btn_run),
    .btn_halt  (btn_halt),
    .btn_step  (btn_step),
    .btn_slow  (btn_slow),
    .cpu_rst_n (cpu_rst_n),
    .cpu_halt  (cpu_halt),
    .run_state (run_state),
    .step_count(step_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: raw samples delayed two clocks, a mismatch streak per
  // button, and a mode number matching the run_state encoding.
  logic [3:0]  m_h0, m_h1, m_db, m_rose;
  int          m_streak [4];
  int          m_mode;
  int          m_age;
  logic [15:0] m_cnt;
  logic        m_rstn;

  function automatic logic m_halt_f();
    if (m_mode == 1 || m_mode == 2) return 1'b0;
    if (m_mode == 3) return ((m_age % SP) != SP - 1);
    return 1'b1;
  endfunction

  task automatic model_edge();
    logic [3:0] raw;
    logic [3:0] p;
    raw = {btn_slow, btn_step, btn_halt, btn_run};
    if (sw0) begin
      m_h0 = '0; m_h1 = '0; m_db = '0; m_rose = '0;
      for (int b = 0; b < 4; b++) m_streak[b] = 0;
      m_mode = 0; m_age = 0; m_cnt = '0; m_rstn = 1'b0;
      return;
    end
    if (!m_halt_f() && m_rstn) m_cnt = m_cnt + 16'd1;
    p = m_rose;
    for (int b = 0; b < 4; b++) begin
      m_rose[b] = 1'b0;
      if (m_h1[b] != m_db[b]) begin
        m_streak[b]++;
        if (m_streak[b] == DB) begin
          m_db[b]     = m_h1[b];
          m_streak[b] = 0;
          m_rose[b]   = m_db[b];
        end
      end else begin
        m_streak[b] = 0;
      end
    end
    m_h1 = m_h0;
    m_h0 = raw;
    case (m_mode)
      0: begin
        if (!p[1]) begin
          if (p[2]) m_mode = 2;
          else if (p[0]) m_mode = 1;
          else if (p[3]) begin m_mode = 3; m_age = 0; end
        end
      end
      1: if (p[1] || p[2] || p[3]) m_mode = 0;
      2: m_mode = 0;
      default: begin
        if (p[1]) m_mode = 0;
        else if (p[0]) m_mode = 1;
        else m_age++;
      end
    endcase
    m_rstn = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("model_rst_n", cpu_rst_n, m_rstn);
    check("model_halt", cpu_halt, m_halt_f());
    check("model_state", run_state, m_mode);
    check("model_count", step_count, m_cnt);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic wait_state(input logic [1:0] target, input int max_cyc, input string name);
    for (int k = 0; k < max_cyc; k++) begin
      tick();
      if (run_state == target) break;
    end
    check(name, run_state, target);
  endtask

  typedef struct {
    logic        sw;
    logic        step;
    logic        rstn;
    logic        chalt;
    logic [1:0]  st;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [34];

  task automatic set_vec(input int lo, input int hi, input logic sw, input logic step,
                         input logic rstn, input logic chalt, input logic [1:0] st,
                         input logic [15:0] cnt);
    for (int i = lo; i <= hi; i++) begin
      tbl[i].sw = sw; tbl[i].step = step; tbl[i].rstn = rstn;
      tbl[i].chalt = chalt; tbl[i].st = st; tbl[i].cnt = cnt;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    logic [15:0] c0;
    // Reset, then hold step from vector 5 (edge 0): STEP after edge 6.
    set_vec(0, 2,   1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 16'd0);
    set_vec(3, 4,   1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 16'd0);
    set_vec(5, 10,  1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 16'd0);
    set_vec(11, 11, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 16'd0);
    set_vec(12, 15, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 16'd1);
    set_vec(16, 23, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 16'd1);
    set_vec(24, 29, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 16'd1);
    set_vec(30, 30, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 16'd1);
    set_vec(31, 33, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 16'd2);

    for (int i = 0; i < 34; i++) begin
      sw0 = tbl[i].sw;
      btn_step = tbl[i].step;
      tick();
      check("vec_rst_n", cpu_rst_n, tbl[i].rstn);
      check("vec_halt", cpu_halt, tbl[i].chalt);
      check("vec_state", run_state, tbl[i].st);
      check("vec_count", step_count, tbl[i].cnt);
    end
    btn_step = 1'b0;
    ticks(10);

    // Glitch of three cycles must be ignored.
    btn_run = 1'b1; ticks(3); btn_run = 1'b0; ticks(10);
    check("glitch_state", run_state, 2'd0);
    check("glitch_count", step_count, 16'd2);

    // Proper run press, count advances every cycle.
    btn_run = 1'b1;
    wait_state(2'd1, 20, "run_enter");
    btn_run = 1'b0;
    ticks(5);
    check("run_count", step_count, 16'd7);

    btn_halt = 1'b1;
    wait_state(2'd0, 20, "halt_enter");
    btn_halt = 1'b0;
    ticks(10);

    // Slow-run: one enabled cycle in every SP, first at cycle SP-1.
    btn_slow = 1'b1;
    wait_state(2'd3, 20, "slow_enter");
    btn_slow = 1'b0;
    c0 = m_cnt;
    for (int i = 1; i < 24; i++) begin
      tick();
      check("slow_halt", cpu_halt, (i % SP == SP - 1) ? 1'b0 : 1'b1);
    end
    tick();
    check("slow_count", step_count, c0 + 16'd3);
    btn_halt = 1'b1;
    wait_state(2'd0, 20, "slow_halt_enter");
    btn_halt = 1'b0;
    c0 = m_cnt;
    ticks(20);
    check("halt_frozen", step_count, c0);

    // halt beats run while HALTED.
    btn_halt = 1'b1; btn_run = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("prio_halted", run_state, 2'd0);
    end
    btn_halt = 1'b0; btn_run = 1'b0;
    ticks(10);

    // halt beats run while RUNNING.
    btn_run = 1'b1;
    wait_state(2'd1, 20, "prio_run_enter");
    btn_run = 1'b0;
    ticks(10);
    btn_halt = 1'b1; btn_run = 1'b1;
    wait_state(2'd0, 20, "prio_running");
    btn_halt = 1'b0; btn_run = 1'b0;
    ticks(10);
    check("prio_settled", run_state, 2'd0);

    // Reset in the middle of RUNNING.
    btn_run = 1'b1;
    wait_state(2'd1, 20, "mid_run_enter");
    btn_run = 1'b0;
    ticks(3);
    sw0 = 1'b1;
    tick();
    check("mid_rst_state", run_state, 2'd0);
    check("mid_rst_count", step_count, 16'd0);
    check("mid_rst_n", cpu_rst_n, 1'b0);
    sw0 = 1'b0;
    tick();
    check("mid_rst_release", cpu_rst_n, 1'b1);
    ticks(10);

    // Random button traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 4) == 0) btn_run  = ~btn_run;
      if ($urandom_range(0, 4) == 0) btn_halt = ~btn_halt;
      if ($urandom_range(0, 4) == 0) btn_step = ~btn_step;
      if ($urandom_range(0, 4) == 0) btn_slow = ~btn_slow;
      sw0 = ($urandom_range(0, 199) == 0);
      tick();
    end
    btn_run = 1'b0; btn_halt = 1'b0; btn_step = 1'b0; btn_slow = 1'b0;
    sw0 = 1'b1; ticks(2); sw0 = 1'b0; ticks(10);

    // Counter wrap in RUNNING.
    btn_run = 1'b1;
    wait_state(2'd1, 20, "wrap_enter");
    btn_run = 1'b0;
    for (int k = 0; k < 70000; k++) begin
      if (step_count == 16'hFFFE) break;
      tick();
    end
    check("wrap_reach", step_count, 16'hFFFE);
    tick();
    check("wrap_ffff", step_count, 16'hFFFF);
    tick();
    check("wrap_zero", step_count, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
